// File: rtl/vc_scheduler.sv
// Two-VC round-robin scheduler feeding two destination FIFOs, with a small
// control FSM that owns the FIFO threshold registers and error handling.
module vc_scheduler #(
    parameter int VC_TH_W = 4,
    parameter int D_TH_W  = 2
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic               init,
    input  logic [VC_TH_W-1:0] afVC_in,
    input  logic [VC_TH_W-1:0] aeVC_in,
    input  logic [D_TH_W-1:0]  afD_in,
    input  logic [D_TH_W-1:0]  aeD_in,
    input  logic               fifo_empty_vc0,
    input  logic               fifo_empty_vc1,
    input  logic               head_dest_vc0,
    input  logic               head_dest_vc1,
    input  logic               fifo_pause_d0,
    input  logic               fifo_pause_d1,
    input  logic               fifo_empty_d0,
    input  logic               fifo_empty_d1,
    input  logic               fifo_error_any,
    output logic               pop_vc0,
    output logic               pop_vc1,
    output logic               pop_delay_vc0,
    output logic               pop_delay_vc1,
    output logic [VC_TH_W-1:0] afVC_o,
    output logic [VC_TH_W-1:0] aeVC_o,
    output logic [D_TH_W-1:0]  afD_o,
    output logic [D_TH_W-1:0]  aeD_o,
    output logic [2:0]         state,
    output logic               idle_out,
    output logic               error_out
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t cur;
    state_t nxt;
    logic   last_grant;
    logic   elig0;
    logic   elig1;

    always_comb begin
        nxt = cur;
        if (cur == S_RESET) begin
            nxt = S_INIT;
        end else if (fifo_error_any || cur == S_ERROR) begin
            nxt = S_ERROR;
        end else begin
            case (cur)
                S_INIT:   nxt = init ? S_INIT : S_IDLE;
                S_IDLE: begin
                    if (init)
                        nxt = S_INIT;
                    else if (!fifo_empty_vc0 || !fifo_empty_vc1)
                        nxt = S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (init)
                        nxt = S_INIT;
                    else if (fifo_empty_vc0 && fifo_empty_vc1 && fifo_empty_d0 && fifo_empty_d1)
                        nxt = S_IDLE;
                end
                default:  nxt = cur;
            endcase
        end
    end

    // A VC is blocked when the destination its head word targets is pausing.
    assign elig0 = (cur == S_ACTIVE) && !fifo_empty_vc0 &&
                   !(head_dest_vc0 ? fifo_pause_d1 : fifo_pause_d0);
    assign elig1 = (cur == S_ACTIVE) && !fifo_empty_vc1 &&
                   !(head_dest_vc1 ? fifo_pause_d1 : fifo_pause_d0);

    assign pop_vc0 = elig0 && (!elig1 || last_grant);
    assign pop_vc1 = elig1 && (!elig0 || !last_grant);
    assign state   = cur;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cur           <= S_RESET;
            idle_out      <= 1'b0;
            error_out     <= 1'b0;
            last_grant    <= 1'b1;
            pop_delay_vc0 <= 1'b0;
            pop_delay_vc1 <= 1'b0;
            afVC_o        <= '0;
            aeVC_o        <= '0;
            afD_o         <= '0;
            aeD_o         <= '0;
        end else begin
            cur           <= nxt;
            idle_out      <= (nxt == S_IDLE);
            error_out     <= (nxt == S_ERROR);
            pop_delay_vc0 <= pop_vc0;
            pop_delay_vc1 <= pop_vc1;
            if (pop_vc0)
                last_grant <= 1'b0;
            else if (pop_vc1)
                last_grant <= 1'b1;
            if (cur == S_INIT) begin
                afVC_o <= afVC_in;
                aeVC_o <= aeVC_in;
                afD_o  <= afD_in;
                aeD_o  <= aeD_in;
            end
        end
    end

endmodule

// File: tb/tb_vc_scheduler.sv
// Directed bench for vc_scheduler: a cycle model derived from the scheduling
// rules is compared every cycle, plus literal checkpoints along the sequence.
module tb_vc_scheduler;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       init;
    logic [3:0] afVC_in, aeVC_in;
    logic [1:0] afD_in, aeD_in;
    logic       fifo_empty_vc0, fifo_empty_vc1, head_dest_vc0, head_dest_vc1;
    logic       fifo_pause_d0, fifo_pause_d1, fifo_empty_d0, fifo_empty_d1;
    logic       fifo_error_any;
    logic       pop_vc0, pop_vc1, pop_delay_vc0, pop_delay_vc1;
    logic [3:0] afVC_o, aeVC_o;
    logic [1:0] afD_o, aeD_o;
    logic [2:0] state;
    logic       idle_out, error_out;

    int total = 0;
    int bad   = 0;
    bit run   = 0;

    vc_scheduler #(.VC_TH_W(4), .D_TH_W(2)) dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .afVC_in(afVC_in), .aeVC_in(aeVC_in), .afD_in(afD_in), .aeD_in(aeD_in),
        .fifo_empty_vc0(fifo_empty_vc0), .fifo_empty_vc1(fifo_empty_vc1),
        .head_dest_vc0(head_dest_vc0), .head_dest_vc1(head_dest_vc1),
        .fifo_pause_d0(fifo_pause_d0), .fifo_pause_d1(fifo_pause_d1),
        .fifo_empty_d0(fifo_empty_d0), .fifo_empty_d1(fifo_empty_d1),
        .fifo_error_any(fifo_error_any),
        .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
        .pop_delay_vc0(pop_delay_vc0), .pop_delay_vc1(pop_delay_vc1),
        .afVC_o(afVC_o), .aeVC_o(aeVC_o), .afD_o(afD_o), .aeD_o(aeD_o),
        .state(state), .idle_out(idle_out), .error_out(error_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model state: 0 reset, 1 init, 2 idle, 3 active, 4 error
    int m_state, m_last, m_pd0, m_pd1, m_afvc, m_aevc, m_afd, m_aed;

    function automatic void model_reset();
        m_state = 0; m_last = 1; m_pd0 = 0; m_pd1 = 0;
        m_afvc = 0; m_aevc = 0; m_afd = 0; m_aed = 0;
    endfunction

    // Which VC must pop now, given model state and the present inputs.
    function automatic void model_pops(output int p0, output int p1);
        int can [2];
        p0 = 0; p1 = 0;
        if (m_state != 3) return;
        can[0] = (!fifo_empty_vc0 && !(head_dest_vc0 ? fifo_pause_d1 : fifo_pause_d0)) ? 1 : 0;
        can[1] = (!fifo_empty_vc1 && !(head_dest_vc1 ? fifo_pause_d1 : fifo_pause_d0)) ? 1 : 0;
        if (can[0] + can[1] == 2) begin
            if (m_last == 0) p1 = 1; else p0 = 1;
        end else begin
            p0 = can[0];
            p1 = can[1];
        end
    endfunction

    always @(negedge reset_L) model_reset();

    always @(posedge clk) begin
        int p0, p1;
        if (!reset_L) begin
            model_reset();
        end else begin
            model_pops(p0, p1);
            if (p0 == 1) m_last = 0;
            if (p1 == 1) m_last = 1;
            m_pd0 = p0;
            m_pd1 = p1;
            if (m_state == 1) begin
                m_afvc = int'(afVC_in); m_aevc = int'(aeVC_in);
                m_afd  = int'(afD_in);  m_aed  = int'(aeD_in);
            end
            if (m_state == 0) m_state = 1;
            else if (fifo_error_any || m_state == 4) m_state = 4;
            else if (init) m_state = 1;
            else if (m_state == 1) m_state = 2;
            else if (m_state == 2 && (!fifo_empty_vc0 || !fifo_empty_vc1)) m_state = 3;
            else if (m_state == 3 && fifo_empty_vc0 && fifo_empty_vc1 && fifo_empty_d0 && fifo_empty_d1)
                m_state = 2;
        end
    end

    always @(negedge clk) begin
        int p0, p1;
        if (run) begin
            model_pops(p0, p1);
            check("state", int'(state), m_state);
            check("pop_vc0", int'(pop_vc0), p0);
            check("pop_vc1", int'(pop_vc1), p1);
            check("pop_delay_vc0", int'(pop_delay_vc0), m_pd0);
            check("pop_delay_vc1", int'(pop_delay_vc1), m_pd1);
            check("idle_out", int'(idle_out), (m_state == 2) ? 1 : 0);
            check("error_out", int'(error_out), (m_state == 4) ? 1 : 0);
            check("afVC_o", int'(afVC_o), m_afvc);
            check("aeVC_o", int'(aeVC_o), m_aevc);
            check("afD_o", int'(afD_o), m_afd);
            check("aeD_o", int'(aeD_o), m_aed);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        model_reset();
        reset_L = 1'b0; init = 1'b0;
        afVC_in = 4'h0; aeVC_in = 4'h0; afD_in = 2'h0; aeD_in = 2'h0;
        fifo_empty_vc0 = 1'b1; fifo_empty_vc1 = 1'b1;
        head_dest_vc0 = 1'b0; head_dest_vc1 = 1'b0;
        fifo_pause_d0 = 1'b0; fifo_pause_d1 = 1'b0;
        fifo_empty_d0 = 1'b1; fifo_empty_d1 = 1'b1;
        fifo_error_any = 1'b0;
        run = 1;
        tick(); tick();
        #1 check("lit_reset_state", int'(state), 0);
        check("lit_reset_afVC", int'(afVC_o), 0);

        // Threshold load sequence
        afVC_in = 4'hC; aeVC_in = 4'h2; afD_in = 2'h3; aeD_in = 2'h1; init = 1'b1;
        reset_L = 1'b1;
        tick(); #1 check("lit_init_s1", int'(state), 1);
        tick(); #1 check("lit_init_s2", int'(state), 1);
        init = 1'b0;
        tick(); #1 check("lit_idle", int'(state), 2);
        check("lit_afVC", int'(afVC_o), 12);
        check("lit_aeVC", int'(aeVC_o), 2);
        check("lit_afD", int'(afD_o), 3);
        check("lit_aeD", int'(aeD_o), 1);
        check("lit_idle_out", int'(idle_out), 1);
        afVC_in = 4'h5; aeVC_in = 4'h9; afD_in = 2'h0; aeD_in = 2'h2;

        // Alternating grants
        fifo_empty_vc0 = 1'b0; fifo_empty_vc1 = 1'b0; fifo_empty_d0 = 1'b0;
        head_dest_vc0 = 1'b0; head_dest_vc1 = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1 check("lit_rr_pop0", int'(pop_vc0), (i % 2 == 0) ? 1 : 0);
            check("lit_rr_pop1", int'(pop_vc1), (i % 2 == 1) ? 1 : 0);
            check("lit_rr_dly0", int'(pop_delay_vc0), (i % 2 == 1) ? 1 : 0);
            tick();
        end
        check("lit_hold_afVC", int'(afVC_o), 12);

        // Both heads to paused D1; vc1 popped last, so vc0 goes first afterwards
        head_dest_vc0 = 1'b1; head_dest_vc1 = 1'b1; fifo_pause_d1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("lit_pause_pop0", int'(pop_vc0), 0);
            check("lit_pause_pop1", int'(pop_vc1), 0);
            tick();
        end
        fifo_pause_d1 = 1'b0;
        #1 check("lit_resume_pop0", int'(pop_vc0), 1);
        check("lit_resume_pop1", int'(pop_vc1), 0);
        tick();

        // Drain to IDLE, then wake on vc1
        fifo_empty_vc0 = 1'b1; fifo_empty_vc1 = 1'b1; fifo_empty_d0 = 1'b1;
        tick(); #1 check("lit_drain_idle", int'(state), 2);
        check("lit_drain_idle_out", int'(idle_out), 1);
        fifo_empty_vc1 = 1'b0;
        tick(); #1 check("lit_wake_state", int'(state), 3);
        check("lit_wake_pop1", int'(pop_vc1), 1);

        // Error pulse is absorbing
        fifo_empty_vc0 = 1'b0; fifo_error_any = 1'b1;
        tick(); fifo_error_any = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("lit_err_state", int'(state), 4);
            check("lit_err_out", int'(error_out), 1);
            check("lit_err_pops", int'(pop_vc0 | pop_vc1), 0);
            init = (i == 1);
            tick();
        end
        init = 1'b0;

        // Reset, re-init, then return to INIT from ACTIVE
        reset_L = 1'b0; tick();
        afVC_in = 4'h5; aeVC_in = 4'h1; afD_in = 2'h2; aeD_in = 2'h0; init = 1'b1;
        fifo_empty_vc1 = 1'b1; head_dest_vc0 = 1'b0;
        reset_L = 1'b1;
        tick(); tick(); init = 1'b0;
        tick(); #1 check("lit_reinit_afVC", int'(afVC_o), 5);
        tick(); #1 check("lit_act_pop0", int'(pop_vc0), 1);
        init = 1'b1;
        tick(); #1 check("lit_back_init", int'(state), 1);
        check("lit_back_init_pop", int'(pop_vc0), 0);
        init = 1'b0;
        tick(); tick();
        #1 check("lit_act2_pop0", int'(pop_vc0), 1);

        // Asynchronous reset kills the pop without a clock edge
        #1 reset_L = 1'b0;
        #1 check("lit_async_pop0", int'(pop_vc0), 0);
        check("lit_async_state", int'(state), 0);
        check("lit_async_afVC", int'(afVC_o), 0);
        check("lit_async_pd0", int'(pop_delay_vc0), 0);
        tick(); tick();
        run = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vc_scheduler.md
VC_SCHEDULER -- requirements
Module: vc_scheduler

Interface
REQ-001 Parameter: VC_TH_W, default 4, width of VC FIFO threshold buses.
REQ-002 Parameter: D_TH_W, default 2, width of destination FIFO threshold buses.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low (clk, reset_L).
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset_L  in  1  asynchronous active-low reset.
REQ-006 init  in  1  request to (re)load thresholds.
REQ-007 afVC_in, aeVC_in  in  VC_TH_W each  requested VC almost-full/almost-empty thresholds.
REQ-008 afD_in, aeD_in  in  D_TH_W each  requested destination almost-full/almost-empty thresholds.
REQ-009 fifo_empty_vc0, fifo_empty_vc1  in  1 each  VC FIFO empty flags.
REQ-010 head_dest_vc0, head_dest_vc1  in  1 each  destination bit of each VC FIFO head word (0 = D0, 1 = D1).
REQ-011 fifo_pause_d0, fifo_pause_d1  in  1 each  destination FIFO almost-full flags.
REQ-012 fifo_empty_d0, fifo_empty_d1  in  1 each  destination FIFO empty flags.
REQ-013 fifo_error_any  in  1  OR of all FIFO overflow/underflow errors.
REQ-014 pop_vc0, pop_vc1  out  1 each  combinational pop strobes to VC FIFOs.
REQ-015 pop_delay_vc0, pop_delay_vc1  out  1 each  pop strobes delayed one cycle; the valid for the VC-to-destination mux.
REQ-016 afVC_o, aeVC_o  out  VC_TH_W each; afD_o, aeD_o  out  D_TH_W each  active thresholds.
REQ-017 state  out  3  FSM state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
REQ-018 idle_out, error_out  out  1 each  high while state is IDLE / ERROR respectively.

Function
REQ-019 Registered FSM, transitions evaluated on each rising clk edge, priority in listed order.
REQ-020 RESET -> INIT unconditionally on the first edge after reset_L deasserts.
REQ-021 Any state except RESET -> ERROR when fifo_error_any=1; ERROR is absorbing until reset_L low.
REQ-022 INIT: threshold registers load afVC_in/aeVC_in/afD_in/aeD_in on every edge in INIT; INIT -> IDLE when init=0, else stays.
REQ-023 IDLE or ACTIVE -> INIT when init=1; pops stop in the cycle state becomes INIT.
REQ-024 IDLE -> ACTIVE when fifo_empty_vc0=0 or fifo_empty_vc1=0.
REQ-025 ACTIVE -> IDLE when all four empty flags (vc0, vc1, d0, d1) are 1.
REQ-026 Threshold outputs change only in INIT; held unchanged in IDLE, ACTIVE, ERROR.
REQ-027 Eligibility: eligible_i = (state==ACTIVE) & ~fifo_empty_vc_i & ~pause_of(head_dest_vc_i), pause_of(0)=fifo_pause_d0, pause_of(1)=fifo_pause_d1.
REQ-028 At most one of pop_vc0/pop_vc1 high per cycle.
REQ-029 Round robin: both eligible -> grant the VC not equal to last_grant; one eligible -> grant it; none -> no pop.
REQ-030 last_grant register updates to the granted VC on every cycle with a pop, else holds.
REQ-031 pop_delay_vcX = pop_vcX registered one cycle, unconditionally (including the cycle after leaving ACTIVE).
REQ-032 Both VCs head to the same paused destination -> no pop; pop resumes the first cycle the pause flag is 0.

Reset
REQ-033 reset_L low, asynchronously: state=RESET, last_grant=1 (VC0 wins first tie), pop_delay_vc0/1=0, all threshold outputs 0.
REQ-034 In RESET: pop_vc0/1=0, idle_out=0, error_out=0; reset asserted mid-ACTIVE kills pops immediately (combinational).

Verification
REQ-035 Reset release, init=1 for 2 cycles with afVC_in=4'hC, aeVC_in=4'h2, afD_in=2'h3, aeD_in=2'h1, then init=0 -> state 0,1,1,2; outputs C/2/3/1.
REQ-036 ACTIVE, both VCs non-empty, heads to D0 and D1, no pause -> pops alternate vc0, vc1, vc0 ...; pop_delay mirrors one cycle later.
REQ-037 Both heads dest=1, fifo_pause_d1=1 for 3 cycles -> no pops for 3 cycles; VC with last_grant!=it pops first after release.
REQ-038 fifo_error_any pulsed 1 cycle in ACTIVE -> state=4, error_out=1, no pops thereafter until reset_L low.
REQ-039 All four empty flags 1 in ACTIVE -> IDLE next edge, idle_out=1; vc1 non-empty -> ACTIVE next edge, pop_vc1=1 that cycle.
REQ-040 reset_L low mid-stream with pop_vc0=1 -> pop_vc0=0 same cycle, state=0, thresholds 0, no clock edge required.
